pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives write-enable and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB stage registers.
- Covers load-use hazards, taken branches resolved in MEM (branch flag plus zeroALU_MEM), and variable-latency data-memory accesses, with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 16, max cycles a MEM access may wait for mem_ready before fatal halt (range 2..255)
- CNT_W, 8, width of wait counter

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- rs_ID  in  5  rs field of instruction in ID
- rt_ID  in  5  rt field of instruction in ID
- rt_EX  in  5  destination rt of instruction in EX
- MemRead_EX  in  1  EX instruction is a load
- Branch_MEM  in  1  MEM instruction is a conditional branch
- zeroALU_MEM  in  1  ALU zero flag latched in EX_MEM
- mem_req_MEM  in  1  MEM instruction accesses data memory (load or store)
- mem_ready  in  1  data memory completes access this cycle
- PC_write  out  1  PC load enable
- PCSrc  out  1  select branch target (PC_next_MEM) for PC
- IF_ID_write  out  1  IF_ID hold when 0
- IF_ID_flush  out  1  IF_ID cleared to NOP
- ID_EX_flush  out  1  ID_EX controls zeroed (bubble)
- EX_MEM_write  out  1  EX_MEM hold when 0
- EX_MEM_flush  out  1  EX_MEM controls zeroed
- MEM_WB_bubble  out  1  MEM_WB captures NOP
- mem_error  out  1  sticky timeout flag

Behaviour:
- States: RUN, MEM_WAIT, HALT. Reset (async) → RUN, wait counter = 0, mem_error = 0.
- All control outputs are combinational from state and inputs, valid the same cycle. Registers act on the next clk edge.
- Default in RUN with no events: PC_write=1, IF_ID_write=1, EX_MEM_write=1, all flush/bubble=0, PCSrc=0.
- Priority, highest first: HALT, memory freeze, branch taken, load-use.
- Memory freeze: asserted in RUN when mem_req_MEM=1 and mem_ready=0, and throughout MEM_WAIT while mem_ready=0.
  - Outputs during freeze: PC_write=0, IF_ID_write=0, EX_MEM_write=0, MEM_WB_bubble=1, no flushes, PCSrc=0.
- RUN → MEM_WAIT when mem_req_MEM=1 and mem_ready=0. Counter is loaded with 1.
- mem_ready=1 with mem_req_MEM=1 in RUN: zero-wait access, no freeze, stay in RUN.
- MEM_WAIT behaviour:
  - Counter increments each cycle.
  - When mem_ready=1: no freeze that cycle, normal advance, → RUN, counter cleared.
  - When counter == MEM_TIMEOUT and mem_ready=0: → HALT, mem_error set.
  - mem_ready arriving in the same cycle as the timeout wins: → RUN, no error.
- HALT outputs: PC_write=0, IF_ID_write=0, EX_MEM_write=0, MEM_WB_bubble=1. Exit only by reset. mem_error stays 1 until reset.
- Branch taken = Branch_MEM & zeroALU_MEM, evaluated in RUN only.
  - Outputs: PCSrc=1, PC_write=1, IF_ID_flush=1, ID_EX_flush=1, EX_MEM_flush=1.
  - Any simultaneous load-use detection is ignored, since the ID instruction is being flushed.
- Load-use = MemRead_EX & (rt_EX != 0) & ((rt_EX == rs_ID) | (rt_EX == rt_ID)).
  - Outputs: PC_write=0, IF_ID_write=0, ID_EX_flush=1, EX_MEM_write=1.
  - Exactly one bubble results, because the load leaves EX on the next edge.
- Memory freeze masks a concurrent load-use: the EX/ID relationship is preserved, so the load-use stall occurs after the freeze ends.
- Reset mid-wait: immediate return to RUN. No residual freeze in the cycle after reset deasserts.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three outputs, all cleared on reset and saturating at all-ones:
  - stall_cycles (32-bit): +1 for each freeze or load-use cycle
  - flush_events (16-bit): +1 for each taken branch
  - max_wait (CNT_W-bit): largest completed MEM_WAIT count
- When undefined, these ports and their logic are absent and the core behaviour is identical.

Decomposition:
- Shared package pipeline_pkg:
  - state enum (RUN, MEM_WAIT, HALT)
  - REG_ZERO = 5'd0
  - default MEM_TIMEOUT constant
- One natural sub-module, hazard_detect: the purely combinational load-use compare. Instantiated once.
- The FSM and counters live in the top module.

Test Plan:
- Load-use: MemRead_EX=1, rt_EX=5, rs_ID=5 → one cycle with PC_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle defaults restored.
- Load to $0: MemRead_EX=1, rt_EX=0, rs_ID=0 → no stall; also rt_EX=7, rt_ID=7 with MemRead_EX=0 → no stall.
- Branch taken plus load-use in the same cycle: Branch_MEM=1, zeroALU_MEM=1 → PCSrc=1, all three flushes=1, PC_write=1; Branch_MEM=1, zeroALU_MEM=0 → no flush.
- Memory wait: mem_req_MEM=1, mem_ready low for 3 cycles then high → freeze for exactly 3 cycles, advance on the 4th, state back to RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → HALT entered with mem_error=1 after the 4th wait cycle and held for 20 more cycles; reset returns RUN with mem_error=0.
- Reset asserted asynchronously mid-MEM_WAIT (between clock edges) → outputs immediately at defaults, counter 0. With HAZARD_PERF_CNT_EN, stall_cycles = 0 after reset.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         MEM_TIMEOUT_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl_if
// Brief   : Pipeline-side hazard inputs and stage-register controls.
//           Performance outputs exist only with HAZARD_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int CNT_W = 8)
`endif
;
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic [4:0] rt_EX;
    logic       MemRead_EX;
    logic       Branch_MEM;
    logic       zeroALU_MEM;
    logic       mem_req_MEM;
    logic       mem_ready;

    logic       PC_write;
    logic       PCSrc;
    logic       IF_ID_write;
    logic       IF_ID_flush;
    logic       ID_EX_flush;
    logic       EX_MEM_write;
    logic       EX_MEM_flush;
    logic       MEM_WB_bubble;
    logic       mem_error;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]      stall_cycles;
    logic [15:0]      flush_events;
    logic [CNT_W-1:0] max_wait;
`endif

    modport master (
        output rs_ID, rt_ID, rt_EX, MemRead_EX, Branch_MEM, zeroALU_MEM,
               mem_req_MEM, mem_ready,
        input  PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush,
               EX_MEM_write, EX_MEM_flush, MEM_WB_bubble, mem_error
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cycles, flush_events, max_wait
`endif
    );

    modport slave (
        input  rs_ID, rt_ID, rt_EX, MemRead_EX, Branch_MEM, zeroALU_MEM,
               mem_req_MEM, mem_ready,
        output PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush,
               EX_MEM_write, EX_MEM_flush, MEM_WB_bubble, mem_error
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cycles, flush_events, max_wait
`endif
    );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational load-use compare between the EX load and ID sources.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_detect
    import pipeline_pkg::*;
(
    input  wire logic       i_mem_read_ex,
    input  wire logic [4:0] i_rt_ex,
    input  wire logic [4:0] i_rs_id,
    input  wire logic [4:0] i_rt_id,
    output logic            o_load_use
);

    // A load into $0 never produces a value, so it cannot cause a hazard.
    assign o_load_use = i_mem_read_ex && (i_rt_ex != REG_ZERO) &&
                        ((i_rt_ex == i_rs_id) || (i_rt_ex == i_rt_id));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush sequencer for the 5-stage pipeline with MEM watchdog.
//           Optional counters enabled by HAZARD_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_freeze;
    logic             w_load_use;
    logic             w_branch;

    hazard_detect u_hazard_detect (
        .i_mem_read_ex (bus.MemRead_EX),
        .i_rt_ex       (bus.rt_EX),
        .i_rs_id       (bus.rs_ID),
        .i_rt_id       (bus.rt_ID),
        .o_load_use    (w_load_use)
    );

    assign w_branch = bus.Branch_MEM & bus.zeroALU_MEM;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_state_nxt == HALT) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_freeze    = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.mem_req_MEM && !bus.mem_ready) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = MEM_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                // A ready arriving on the timeout cycle still completes the access.
                if (bus.mem_ready) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = HALT;
                end else begin
                    w_freeze    = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        bus.PC_write      = 1'b1;
        bus.PCSrc         = 1'b0;
        bus.IF_ID_write   = 1'b1;
        bus.IF_ID_flush   = 1'b0;
        bus.ID_EX_flush   = 1'b0;
        bus.EX_MEM_write  = 1'b1;
        bus.EX_MEM_flush  = 1'b0;
        bus.MEM_WB_bubble = 1'b0;
        if ((r_state == HALT) || w_freeze) begin
            bus.PC_write      = 1'b0;
            bus.IF_ID_write   = 1'b0;
            bus.EX_MEM_write  = 1'b0;
            bus.MEM_WB_bubble = 1'b1;
        end else if ((r_state == RUN) && w_branch) begin
            bus.PCSrc        = 1'b1;
            bus.IF_ID_flush  = 1'b1;
            bus.ID_EX_flush  = 1'b1;
            bus.EX_MEM_flush = 1'b1;
        end else if (w_load_use) begin
            bus.PC_write    = 1'b0;
            bus.IF_ID_write = 1'b0;
            bus.ID_EX_flush = 1'b1;
        end
    end

    assign bus.mem_error = r_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]      r_stall_cycles;
    logic [15:0]      r_flush_events;
    logic [CNT_W-1:0] r_max_wait;

    // Freeze and load-use are the only non-halted cycles that hold the PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
            r_max_wait     <= '0;
        end else begin
            if ((r_state != HALT) && !bus.PC_write && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (bus.PCSrc && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
            if ((r_state == MEM_WAIT) && bus.mem_ready && (r_cnt > r_max_wait)) begin
                r_max_wait <= r_cnt;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
    assign bus.max_wait     = r_max_wait;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Scenario bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int P_TIMEOUT = 4;
    localparam int P_CNT_W   = 8;

    // {PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush,
    //  EX_MEM_write, EX_MEM_flush, MEM_WB_bubble, mem_error}
    localparam logic [8:0] DEF = 9'b1_0_1_0_0_1_0_0_0;
    localparam logic [8:0] FRZ = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] BR  = 9'b1_1_1_1_1_1_1_0_0;
    localparam logic [8:0] LU  = 9'b0_0_0_0_1_1_0_0_0;
    localparam logic [8:0] HLT = 9'b0_0_0_0_0_0_0_1_1;

    typedef struct packed {
        logic       mr;
        logic [4:0] rtex;
        logic [4:0] rsid;
        logic [4:0] rtid;
        logic       br;
        logic       z;
        logic       req;
        logic       rdy;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] sb [$];
    logic [8:0] exp_v;
    logic [8:0] obs;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    pipeline_hazard_ctrl_if #(.CNT_W(P_CNT_W)) bus ();
`else
    pipeline_hazard_ctrl_if bus ();
`endif

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (P_TIMEOUT),
        .CNT_W       (P_CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic stim_t S(input int mr, input int rtex, input int rsid, input int rtid,
                                input int br, input int z, input int req, input int rdy);
        stim_t s;
        s.mr   = 1'(mr);
        s.rtex = 5'(rtex);
        s.rsid = 5'(rsid);
        s.rtid = 5'(rtid);
        s.br   = 1'(br);
        s.z    = 1'(z);
        s.req  = 1'(req);
        s.rdy  = 1'(rdy);
        return s;
    endfunction

    function automatic logic [8:0] outs();
        return {bus.PC_write, bus.PCSrc, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_flush,
                bus.EX_MEM_write, bus.EX_MEM_flush, bus.MEM_WB_bubble, bus.mem_error};
    endfunction

    task automatic apply(input stim_t s);
        bus.MemRead_EX  = s.mr;
        bus.rt_EX       = s.rtex;
        bus.rs_ID       = s.rsid;
        bus.rt_ID       = s.rtid;
        bus.Branch_MEM  = s.br;
        bus.zeroALU_MEM = s.z;
        bus.mem_req_MEM = s.req;
        bus.mem_ready   = s.rdy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(S(0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        sb.push_back(DEF);
        exp_v = sb.pop_front();
        obs   = outs();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, exp_v);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_load_use();
        stim_t      s [$];
        logic [8:0] e [$];
        s = '{S(1, 5, 5, 0, 0, 0, 0, 0), S(0, 5, 5, 0, 0, 0, 0, 0),
              S(1, 9, 0, 9, 0, 0, 0, 0), S(0, 0, 0, 0, 0, 0, 0, 0)};
        e = '{LU, DEF, LU, DEF};
        for (int k = 0; k < s.size(); k++) begin
            @(posedge clk); #1;
            apply(s[k]);
            sb.push_back(e[k]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs   = outs();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_no_stall();
        stim_t      s [$];
        logic [8:0] e [$];
        s = '{S(1, 0, 0, 0, 0, 0, 0, 0), S(0, 7, 0, 7, 0, 0, 0, 0),
              S(1, 3, 4, 5, 0, 0, 0, 0)};
        e = '{DEF, DEF, DEF};
        for (int k = 0; k < s.size(); k++) begin
            @(posedge clk); #1;
            apply(s[k]);
            sb.push_back(e[k]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs   = outs();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL no_stall[%0d]: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_branch();
        stim_t      s [$];
        logic [8:0] e [$];
        s = '{S(1, 5, 5, 0, 1, 1, 0, 0), S(0, 0, 0, 0, 1, 0, 0, 0),
              S(1, 6, 0, 6, 1, 0, 0, 0), S(0, 0, 0, 0, 0, 1, 0, 0)};
        e = '{BR, DEF, LU, DEF};
        for (int k = 0; k < s.size(); k++) begin
            @(posedge clk); #1;
            apply(s[k]);
            sb.push_back(e[k]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs   = outs();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t      s [$];
        logic [8:0] e [$];
        s = '{S(0, 0, 0, 0, 0, 0, 1, 0), S(0, 0, 0, 0, 0, 0, 1, 0),
              S(0, 0, 0, 0, 0, 0, 1, 0), S(0, 0, 0, 0, 0, 0, 1, 1),
              S(0, 0, 0, 0, 0, 0, 1, 1), S(0, 0, 0, 0, 0, 0, 0, 0),
              S(0, 0, 0, 0, 1, 1, 1, 0), S(0, 0, 0, 0, 0, 0, 1, 1)};
        e = '{FRZ, FRZ, FRZ, DEF, DEF, DEF, FRZ, DEF};
        for (int k = 0; k < s.size(); k++) begin
            @(posedge clk); #1;
            apply(s[k]);
            sb.push_back(e[k]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs   = outs();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b expected %b", k, obs, exp_v);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (bus.max_wait !== 8'd3) begin
            errors++;
            $display("FAIL perf_max_wait: got %0d expected 3", bus.max_wait);
        end
        checks++;
        if (bus.flush_events !== 16'd1) begin
            errors++;
            $display("FAIL perf_flush_events: got %0d expected 1", bus.flush_events);
        end
`endif
    endtask

    task automatic test_freeze_mask();
        stim_t      s [$];
        logic [8:0] e [$];
        s = '{S(1, 5, 5, 0, 0, 0, 1, 0), S(1, 5, 5, 0, 0, 0, 1, 0),
              S(1, 5, 5, 0, 0, 0, 1, 1), S(0, 0, 0, 0, 0, 0, 0, 0)};
        e = '{FRZ, FRZ, LU, DEF};
        for (int k = 0; k < s.size(); k++) begin
            @(posedge clk); #1;
            apply(s[k]);
            sb.push_back(e[k]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs   = outs();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL freeze_mask[%0d]: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t      s [$];
        logic [8:0] e [$];
        // Second cycle drops the request: only the wait state keeps the freeze.
        s = '{S(0, 0, 0, 0, 0, 0, 1, 0), S(0, 0, 0, 0, 0, 0, 0, 0)};
        e = '{FRZ, FRZ};
        for (int k = 0; k < s.size(); k++) begin
            @(posedge clk); #1;
            apply(s[k]);
            sb.push_back(e[k]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs   = outs();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL async_reset_pre[%0d]: got %b expected %b", k, obs, exp_v);
            end
        end
        #2 reset = 1'b1;
        #1;
        sb.push_back(DEF);
        exp_v = sb.pop_front();
        obs   = outs();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b expected %b", obs, exp_v);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (bus.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_stall_after_reset: got %0d expected 0", bus.stall_cycles);
        end
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        sb.push_back(DEF);
        exp_v = sb.pop_front();
        obs   = outs();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_reset_release: got %b expected %b", obs, exp_v);
        end
    endtask

    task automatic test_timeout_edge();
        stim_t      s [$];
        logic [8:0] e [$];
        s = '{S(0, 0, 0, 0, 0, 0, 1, 0), S(0, 0, 0, 0, 0, 0, 1, 0),
              S(0, 0, 0, 0, 0, 0, 1, 0), S(0, 0, 0, 0, 0, 0, 1, 0),
              S(0, 0, 0, 0, 0, 0, 1, 1), S(0, 0, 0, 0, 0, 0, 0, 0)};
        e = '{FRZ, FRZ, FRZ, FRZ, DEF, DEF};
        for (int k = 0; k < s.size(); k++) begin
            @(posedge clk); #1;
            apply(s[k]);
            sb.push_back(e[k]);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs   = outs();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL timeout_edge[%0d]: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 26; k++) begin
            @(posedge clk); #1;
            // Once halted, ready and branch activity must have no effect.
            if (k < 5) apply(S(0, 0, 0, 0, 0, 0, 1, 0));
            else       apply(S(k % 2, 5, 5, 0, 1, 1, 1, k % 3 == 0 ? 1 : 0));
            sb.push_back(k < 5 ? FRZ : HLT);
            @(negedge clk);
            exp_v = sb.pop_front();
            obs   = outs();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL timeout[%0d]: got %b expected %b", k, obs, exp_v);
            end
        end
        apply(S(0, 0, 0, 0, 0, 0, 0, 0));
        #2 reset = 1'b1;
        #1;
        sb.push_back(DEF);
        exp_v = sb.pop_front();
        obs   = outs();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL timeout_reset: got %b expected %b", obs, exp_v);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        sb.push_back(DEF);
        exp_v = sb.pop_front();
        obs   = outs();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL timeout_after_reset: got %b expected %b", obs, exp_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_freeze_mask();
        test_async_reset();
        test_timeout_edge();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
